// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch state encodings and fetch constants.
// The fetch states reuse the numbering of the top-level control FSM.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 16;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [2:0] {
        F_IDLE    = 3'd0,
        F_CHECK   = 3'd1,
        F_ISSUE   = 3'd2,
        F_WAIT    = 3'd3,
        F_CAPTURE = 3'd4,
        F_DONE    = 3'd5,
        F_FAULT   = 3'd6
    } fetch_state_t;

    // A pc is unusable if it is not word aligned or lies beyond the RAM address space.
    function automatic logic pc_invalid(input logic [XLEN-1:0] pc_v);
        return ((pc_v & ALIGN_MASK) != 32'd0) ||
               (pc_v[XLEN-1:ADDR_W] != {(XLEN-ADDR_W){1'b0}});
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: reads four bytes from a byte-wide RAM at pc and
// assembles them little-endian into one instruction word for decode.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int RAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XLEN-1:0]   pc,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [XLEN-1:0]   instr,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q
);

    localparam logic [3:0] WAIT_LAST = 4'(RAM_LATENCY - 1);

    fetch_state_t    state_r;
    logic [XLEN-1:0] pc_r;
    logic [1:0]      idx_r;
    logic [3:0]      cnt_r;
    logic [XLEN-1:0] shadow_r;
    logic [XLEN-1:0] shadow_nxt_s;

    // Byte lane merge: the RAM byte lands in the lane selected by the current index.
    always_comb begin
        shadow_nxt_s = shadow_r;
        case (idx_r)
            2'd0:    shadow_nxt_s[7:0]   = mem_q;
            2'd1:    shadow_nxt_s[15:8]  = mem_q;
            2'd2:    shadow_nxt_s[23:16] = mem_q;
            2'd3:    shadow_nxt_s[31:24] = mem_q;
            default: shadow_nxt_s        = shadow_r;
        endcase
    end

    // Fetch FSM; every output is registered and reflects the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= F_IDLE;
            pc_r     <= {XLEN{1'b0}};
            idx_r    <= 2'd0;
            cnt_r    <= 4'd0;
            shadow_r <= {XLEN{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
            instr    <= {XLEN{1'b0}};
            mem_rden <= 1'b0;
            mem_addr <= {ADDR_W{1'b0}};
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state_r)
                F_IDLE: begin
                    if (start) begin
                        pc_r    <= pc;
                        idx_r   <= 2'd0;
                        busy    <= 1'b1;
                        state_r <= F_CHECK;
                    end else begin
                        state_r <= F_IDLE;
                    end
                end
                F_CHECK: begin
                    if (pc_invalid(pc_r)) begin
                        busy    <= 1'b0;
                        fault   <= 1'b1;
                        state_r <= F_FAULT;
                    end else begin
                        mem_rden <= 1'b1;
                        mem_addr <= pc_r[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, idx_r};
                        state_r  <= F_ISSUE;
                    end
                end
                F_ISSUE: begin
                    if (RAM_LATENCY == 1) begin
                        mem_rden <= 1'b0;
                        state_r  <= F_CAPTURE;
                    end else begin
                        cnt_r   <= 4'd1;
                        state_r <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        cnt_r    <= 4'd0;
                        mem_rden <= 1'b0;
                        state_r  <= F_CAPTURE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                F_CAPTURE: begin
                    shadow_r <= shadow_nxt_s;
                    if (idx_r == 2'd3) begin
                        // Publish together with done so decode sees a valid word in the pulse cycle.
                        instr   <= shadow_nxt_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= F_DONE;
                    end else begin
                        idx_r    <= idx_r + 2'd1;
                        mem_rden <= 1'b1;
                        mem_addr <= pc_r[ADDR_W-1:0] + {{(ADDR_W-2){1'b0}}, idx_r + 2'd1};
                        state_r  <= F_ISSUE;
                    end
                end
                F_DONE: begin
                    state_r <= F_IDLE;
                end
                F_FAULT: begin
                    state_r <= F_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    mem_rden <= 1'b0;
                    state_r  <= F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a latency-2 and a latency-1 instance share one byte RAM
// model; expected instructions are queued at start and popped when done fires.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            sel = 1'b0;
    logic [XLEN-1:0] pc = '0;

    always #5 clk = ~clk;

    logic              start0, busy0, done0, fault0, rden0;
    logic              start1, busy1, done1, fault1, rden1;
    logic [XLEN-1:0]   instr0, instr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [7:0]        q0, q1;

    assign start0 = start & ~sel;
    assign start1 = start & sel;

    instr_fetch #(.RAM_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .start(start0), .pc(pc),
        .busy(busy0), .done(done0), .fault(fault0), .instr(instr0),
        .mem_rden(rden0), .mem_addr(addr0), .mem_q(q0)
    );

    instr_fetch #(.RAM_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .start(start1), .pc(pc),
        .busy(busy1), .done(done1), .fault(fault1), .instr(instr1),
        .mem_rden(rden1), .mem_addr(addr1), .mem_q(q1)
    );

    // Byte RAM: address sampled on the edge, data after RAM_LATENCY-1 further edges.
    logic [7:0] ram [0:65535];
    logic [7:0] pipe0 [0:1];
    logic [7:0] pipe1;
    always @(posedge clk) begin
        pipe0[0] <= ram[addr0];
        pipe0[1] <= pipe0[0];
        pipe1    <= ram[addr1];
    end
    assign q0 = pipe0[1];
    assign q1 = pipe1;

    logic              s_busy, s_done, s_fault, s_rden;
    logic [XLEN-1:0]   s_instr;
    logic [ADDR_W-1:0] s_addr;
    assign s_busy  = sel ? busy1  : busy0;
    assign s_done  = sel ? done1  : done0;
    assign s_fault = sel ? fault1 : fault0;
    assign s_rden  = sel ? rden1  : rden0;
    assign s_instr = sel ? instr1 : instr0;
    assign s_addr  = sel ? addr1  : addr0;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_instr = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one fetch from an IDLE DUT; returns at the negedge of the cycle after done/fault.
    task automatic fetch(input string tag, input logic [31:0] p, input logic [31:0] exp_instr,
                         input bit exp_fault, input int exp_cyc);
        int          cyc = 0;
        bit          term = 1'b0;
        bit          busy_ok = 1'b1;
        bit          rden_seen = 1'b0;
        bit          prev_rden = 1'b0;
        logic [15:0] addrs[$];
        logic [31:0] exp_v;
        pc    = p;
        start = 1'b1;
        if (!exp_fault) exp_q.push_back(exp_instr);
        while (!term && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (s_rden) rden_seen = 1'b1;
            if (s_rden && !prev_rden) addrs.push_back(s_addr);
            prev_rden = s_rden;
            if (s_done || s_fault) term = 1'b1;
            else if (!s_busy) busy_ok = 1'b0;
        end
        check({tag, " terminated"}, {31'd0, term}, 32'd1);
        check({tag, " cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " done/fault"}, {30'd0, s_done, s_fault}, exp_fault ? 32'd1 : 32'd2);
        check({tag, " busy at end"}, {31'd0, s_busy}, 32'd0);
        check({tag, " busy during"}, {31'd0, busy_ok}, 32'd1);
        if (exp_fault) begin
            check({tag, " rden never"}, {31'd0, rden_seen}, 32'd0);
            check({tag, " instr kept"}, s_instr, last_instr);
        end else begin
            exp_v = exp_q.pop_front();
            check({tag, " instr"}, s_instr, exp_v);
            last_instr = exp_v;
            check({tag, " addr count"}, 32'(addrs.size()), 32'd4);
            for (int i = 0; i < addrs.size(); i++)
                check({tag, " addr"}, {16'd0, addrs[i]}, {16'd0, p[15:0] + 16'(i)});
        end
        @(negedge clk);
        check({tag, " pulse width"}, {30'd0, s_done, s_fault}, 32'd0);
    endtask

    initial begin
        int dcnt;
        int first_done;
        bit dseen;
        logic b15, b16;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0000] = 8'h13; ram[16'h0001] = 8'h00; ram[16'h0002] = 8'h00; ram[16'h0003] = 8'h00;
        ram[16'h0004] = 8'hB3; ram[16'h0005] = 8'h00; ram[16'h0006] = 8'hB5; ram[16'h0007] = 8'h00;
        ram[16'h0008] = 8'h37; ram[16'h0009] = 8'h05; ram[16'h000A] = 8'h00; ram[16'h000B] = 8'h00;
        ram[16'hFFFC] = 8'h11; ram[16'hFFFD] = 8'h22; ram[16'hFFFE] = 8'h33; ram[16'hFFFF] = 8'h44;

        repeat (3) @(negedge clk);
        check("reset busy/done/fault/rden", {28'd0, busy0, done0, fault0, rden0}, 32'd0);
        check("reset addr", {16'd0, addr0}, 32'd0);
        check("reset instr", instr0, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        fetch("nop", 32'h0000_0000, NOP, 1'b0, 14);
        fetch("add b2b", 32'h0000_0004, 32'h00B5_00B3, 1'b0, 14);
        fetch("misaligned", 32'h0000_0002, 32'h0, 1'b1, 2);
        fetch("out of range", 32'h0001_0000, 32'h0, 1'b1, 2);

        // start held high with pc changing mid-fetch
        dcnt = 0; first_done = 0; b15 = 1'bx; b16 = 1'bx;
        pc = 32'h0; start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            if (c == 3) pc = 32'h0000_0008;
            if (s_done) begin
                dcnt++;
                if (dcnt == 1) begin
                    first_done = c;
                    check("hold first instr", s_instr, NOP);
                end
            end
            if (c == 15) b15 = s_busy;
            if (c == 16) begin
                b16 = s_busy;
                start = 1'b0;
            end
        end
        check("hold done count", 32'(dcnt), 32'd2);
        check("hold first done cycle", 32'(first_done), 32'd14);
        check("hold idle busy", {31'd0, b15}, 32'd0);
        check("hold restart busy", {31'd0, b16}, 32'd1);
        check("hold second instr", s_instr, 32'h0000_0537);
        last_instr = 32'h0000_0537;
        @(negedge clk);

        // reset asserted mid-fetch
        pc = 32'h0; start = 1'b1;
        dseen = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (s_done) dseen = 1'b1;
        end
        check("pre-reset busy/rden", {30'd0, s_busy, s_rden}, 32'd3);
        check("pre-reset addr", {16'd0, s_addr}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort busy/rden/done", {29'd0, s_busy, s_rden, s_done}, 32'd0);
        check("abort addr", {16'd0, s_addr}, 32'd0);
        check("abort instr", s_instr, 32'd0);
        repeat (2) begin
            @(negedge clk);
            if (s_done) dseen = 1'b1;
        end
        check("abort no done", {31'd0, dseen}, 32'd0);
        rst = 1'b1;
        last_instr = 32'h0;
        @(negedge clk);

        fetch("post reset", 32'h0000_0004, 32'h00B5_00B3, 1'b0, 14);
        fetch("top of ram", 32'h0000_FFFC, 32'h4433_2211, 1'b0, 14);
        sel = 1'b1;
        @(negedge clk);
        fetch("top latency1", 32'h0000_FFFC, 32'h4433_2211, 1'b0, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
